// File: rtl/arb_mux_pkg.sv
// Shared project definitions for the arbitrating output mux.
// Grant-policy encodings driven onto the mode input.
package arb_mux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating-priority search: first requesting channel at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Scan from the far end so the candidate closest to ptr overwrites the others.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int c;
      c = (int'(ptr) + i) % N;
      if (req[c]) begin
        idx   = SEL_W'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage,
// granting by explicit address or by round-robin.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   addr,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic             load;
  logic             grant;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] gdata;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign load = !out_valid || out_ready;

  // Grant selection; an address at or beyond N never matches a channel.
  always_comb begin
    grant    = 1'b0;
    gidx     = '0;
    in_ready = '0;
    if (!rst && load) begin
      if (mode == MODE_RR) begin
        grant = rr_found;
        gidx  = rr_idx;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (addr == SEL_W'(k) && in_valid[k]) begin
            grant = 1'b1;
            gidx  = addr;
          end
        end
      end
      if (grant) in_ready[gidx] = 1'b1;
    end
  end

  always_comb begin
    gdata = '0;
    for (int k = 0; k < N; k++) begin
      if (gidx == SEL_W'(k)) gdata = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer; the pointer moves only on round-robin grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_sel   <= gidx;
        if (mode == MODE_RR) begin
          rr_ptr <= (gidx == SEL_W'(N - 1)) ? '0 : gidx + SEL_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux: an 8-channel instance plus a
// 6-channel instance for the out-of-range address case.
module tb_arb_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [2:0]   addr;
  logic [7:0]   in_valid;
  logic [127:0] in_data;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [2:0]   out_sel;

  logic         mode6;
  logic [2:0]   addr6;
  logic [5:0]   in_valid6;
  logic [95:0]  in_data6;
  logic [5:0]   in_ready6;
  logic         out_valid6;
  logic         out_ready6;
  logic [15:0]  out_data6;
  logic [2:0]   out_sel6;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(16), .N(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .addr(addr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  arb_mux #(.WIDTH(16), .N(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst(rst), .mode(mode6), .addr(addr6), .in_valid(in_valid6),
    .in_data(in_data6), .in_ready(in_ready6), .out_valid(out_valid6),
    .out_ready(out_ready6), .out_data(out_data6), .out_sel(out_sel6)
  );

  function automatic logic [15:0] dval(int k);
    return 16'(16'h1000 + 16'h0111 * k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern;
    for (int k = 0; k < 8; k++) in_data[k*16 +: 16] = dval(k);
    for (int k = 0; k < 6; k++) in_data6[k*16 +: 16] = dval(k + 8);
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; addr = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    mode6 = 1'b0; addr6 = 3'd0; in_valid6 = 6'h00; out_ready6 = 1'b1;
    load_pattern();
    tick(); tick();
    vectors++;
    if (in_ready !== 8'h00) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %h expected 00", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sel !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h s=%0d expected v=0 d=0000 s=0",
               out_valid, out_data, out_sel);
    end
    rst = 1'b0;
    in_valid = 8'h00;
  endtask

  task automatic test_addr;
    mode = 1'b0; addr = 3'd5; in_valid = 8'h20; out_ready = 1'b1;
    in_data[5*16 +: 16] = 16'hBEEF;
    #1;
    vectors++;
    if (in_ready !== 8'h20) begin
      miscompares++; $display("[TB] FAIL addr_in_ready: got %h expected 20", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL addr_output: got v=%b d=%h s=%0d expected v=1 d=beef s=5",
               out_valid, out_data, out_sel);
    end
    // Address points at an idle channel: no grant, register drains but keeps data.
    addr = 3'd3;
    #1;
    vectors++;
    if (in_ready !== 8'h00) begin
      miscompares++; $display("[TB] FAIL addr_idle_in_ready: got %h expected 00", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL addr_drain: got v=%b d=%h expected v=0 d=beef", out_valid, out_data);
    end
  endtask

  task automatic test_rr_sweep;
    load_pattern();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      int k;
      k = i % 8;
      vectors++;
      if (in_ready !== 8'(1 << k)) begin
        miscompares++;
        $display("[TB] FAIL rr_sweep_in_ready[%0d]: got %h expected %h", i, in_ready, 8'(1 << k));
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== 3'(k) || out_data !== dval(k)) begin
        miscompares++;
        $display("[TB] FAIL rr_sweep_out[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 i, out_valid, out_sel, out_data, k, dval(k));
      end
    end
  endtask

  task automatic test_rr_wrap;
    in_valid = 8'h81;
    #1;
    vectors++;
    if (in_ready !== 8'h80) begin
      miscompares++; $display("[TB] FAIL rr_wrap_first: got %h expected 80", in_ready);
    end
    tick();
    vectors++;
    if (out_sel !== 3'd7 || out_data !== dval(7)) begin
      miscompares++;
      $display("[TB] FAIL rr_wrap_sel7: got s=%0d d=%h expected s=7 d=%h", out_sel, out_data, dval(7));
    end
    vectors++;
    if (in_ready !== 8'h01) begin
      miscompares++; $display("[TB] FAIL rr_wrap_second: got %h expected 01", in_ready);
    end
    tick();
    vectors++;
    if (out_sel !== 3'd0 || out_data !== dval(0)) begin
      miscompares++;
      $display("[TB] FAIL rr_wrap_sel0: got s=%0d d=%h expected s=0 d=%h", out_sel, out_data, dval(0));
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 8'(8'h11 << i);
      in_data[15:0] = 16'(16'hDEAD + i);
      mode = 1'(i);
      addr = 3'(i);
      #1;
      vectors++;
      if (in_ready !== 8'h00) begin
        miscompares++; $display("[TB] FAIL stall_in_ready[%0d]: got %h expected 00", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== dval(0)) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b s=%0d d=%h expected v=1 s=0 d=%h",
                 i, out_valid, out_sel, out_data, dval(0));
      end
    end
    load_pattern();
    mode = 1'b1; in_valid = 8'h04; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h04) begin
      miscompares++; $display("[TB] FAIL stall_release_in_ready: got %h expected 04", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== dval(2)) begin
      miscompares++;
      $display("[TB] FAIL stall_release_out: got v=%b s=%0d d=%h expected v=1 s=2 d=%h",
               out_valid, out_sel, out_data, dval(2));
    end
  endtask

  task automatic test_idle_hold;
    in_valid = 8'h00;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (in_ready !== 8'h00) begin
        miscompares++; $display("[TB] FAIL idle_in_ready[%0d]: got %h expected 00", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL idle_out_valid[%0d]: got %b expected 0", i, out_valid);
      end
    end
    in_valid = 8'hFF;
    #1;
    vectors++;
    if (in_ready !== 8'h08) begin
      miscompares++; $display("[TB] FAIL idle_resume_in_ready: got %h expected 08", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL idle_resume_out: got v=%b s=%0d expected v=1 s=3", out_valid, out_sel);
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sel !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got v=%b d=%h s=%0d expected v=0 d=0000 s=0",
               out_valid, out_data, out_sel);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h00) begin
      miscompares++; $display("[TB] FAIL midreset_in_ready: got %h expected 00", in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 8'h01) begin
      miscompares++; $display("[TB] FAIL postreset_in_ready: got %h expected 01", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== dval(0)) begin
      miscompares++;
      $display("[TB] FAIL postreset_out: got v=%b s=%0d d=%h expected v=1 s=0 d=%h",
               out_valid, out_sel, out_data, dval(0));
    end
  endtask

  task automatic test_addr_n6;
    mode6 = 1'b0; addr6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    #1;
    vectors++;
    if (in_ready6 !== 6'h00) begin
      miscompares++; $display("[TB] FAIL n6_oob_in_ready: got %h expected 00", in_ready6);
    end
    tick();
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL n6_oob_out_valid: got %b expected 0", out_valid6);
    end
    addr6 = 3'd5;
    #1;
    vectors++;
    if (in_ready6 !== 6'h20) begin
      miscompares++; $display("[TB] FAIL n6_last_in_ready: got %h expected 20", in_ready6);
    end
    tick();
    vectors++;
    if (out_valid6 !== 1'b1 || out_sel6 !== 3'd5 || out_data6 !== dval(13)) begin
      miscompares++;
      $display("[TB] FAIL n6_last_out: got v=%b s=%0d d=%h expected v=1 s=5 d=%h",
               out_valid6, out_sel6, out_data6, dval(13));
    end
  endtask

  initial begin
    $display("[TB] starting arb_mux directed tests");
    test_reset();
    test_addr();
    test_rr_sweep();
    test_rr_wrap();
    test_stall();
    test_idle_hold();
    test_reset_midstream();
    test_addr_n6();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of each channel.
REQ-002 Parameter N, default 8, range 2..16, SHALL set the channel count.
REQ-003 Parameter SEL_W, default 3, SHALL equal ceil(log2(N)) and set the select/index width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 mode  input  1  SHALL select the grant policy: 0 = address mode, 1 = round-robin mode.
REQ-007 addr  input  SEL_W  SHALL give the channel index used in address mode.
REQ-008 in_valid  input  N  SHALL carry one valid bit per channel.
REQ-009 in_data  input  N*WIDTH  SHALL hold the channel data, with channel k at bits [k*WIDTH +: WIDTH].
REQ-010 in_ready  output  N  SHALL be one-hot or zero, marking the channel whose word is accepted this cycle.
REQ-011 out_valid  output  1  SHALL indicate that the output register holds a word.
REQ-012 out_ready  input  1  SHALL indicate that the downstream consumer accepts the word this cycle.
REQ-013 out_data  output  WIDTH  SHALL carry the registered word.
REQ-014 out_sel  output  SEL_W  SHALL carry the index of the channel that supplied out_data.

Function
REQ-015 A transfer on channel k SHALL occur in a cycle where in_valid[k] and in_ready[k] are both 1.
REQ-016 The output transfer SHALL occur in a cycle where out_valid and out_ready are both 1.
REQ-017 load SHALL be (!out_valid || out_ready); no channel SHALL be granted when load is 0.
REQ-018 Address mode SHALL grant channel addr if and only if load is 1, addr < N and in_valid[addr] is 1.
REQ-019 Address mode SHALL NOT grant when addr >= N; this is the only case, possible when N is not a power of two.
REQ-020 Round-robin mode SHALL grant the first channel with valid set, scanning rr_ptr, rr_ptr+1, ... with wrap modulo N.
REQ-021 After each round-robin grant to channel k, rr_ptr SHALL become (k+1) mod N; k = N-1 SHALL wrap rr_ptr to 0.
REQ-022 Address-mode grants SHALL leave rr_ptr unchanged.
REQ-023 in_ready SHALL be combinational from mode, addr, in_valid, rr_ptr, out_valid and out_ready; no path from in_data.
REQ-024 On a grant to channel k, the next edge SHALL load out_data with channel k data, set out_sel to k and set out_valid to 1.
REQ-025 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-026 Throughput SHALL be 1 word per cycle while out_ready is held at 1.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_sel SHALL hold stable, and in_ready SHALL be all zero.
REQ-028 When a grant and an output transfer occur in the same cycle, the register SHALL reload and out_valid SHALL stay 1 (no bubble).
REQ-029 When an output transfer occurs without a grant, out_valid SHALL clear on the next edge; out_data SHALL keep its last value.
REQ-030 A mode or addr change SHALL take effect on the next grant only and SHALL NOT alter a word already in the register.
REQ-031 With no in_valid bit set, no grant SHALL occur and rr_ptr SHALL hold.

Reset
REQ-032 While rst=1 at a clock edge: out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
REQ-033 in_ready SHALL be all zero during any cycle with rst=1.
REQ-034 Reset asserted mid-stream SHALL discard the held word without an output transfer.
REQ-035 The first cycle after rst deasserts SHALL be able to grant.

Structure
REQ-036 The mode encodings (MODE_ADDR=0, MODE_RR=1) SHALL live in the shared project defines include, not locally.
REQ-037 WIDTH, N and SEL_W SHALL remain module parameters.
REQ-038 The rotating-priority search SHALL be a combinational sub-module rr_pick (inputs: request vector and rr_ptr; outputs: grant index and grant-valid).
REQ-039 Only the output register and rr_ptr SHALL be sequential.

Verification
REQ-040 Address mode, N=8, addr=5, in_valid=8'h20, D5=16'hBEEF, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=BEEF, out_sel=5.
REQ-041 Round-robin mode after reset, in_valid=8'hFF held, out_ready=1 -> out_sel runs 0,1,...,7,0 on consecutive cycles.
REQ-042 Round-robin mode, in_valid=8'h81, rr_ptr=1 -> grant 7, then rr_ptr=0 and grant 0 (wrap).
REQ-043 out_valid=1 with out_ready=0 for 3 cycles, inputs changing -> out_data/out_sel frozen, in_ready=0; on out_ready=1 a new word is accepted the same cycle.
REQ-044 N=6 address mode, addr=7, in_valid=6'h3F -> no grant, out_valid stays 0.
REQ-045 rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_sel=0, and the next round-robin grant starts at channel 0.
